// File: rtl/eye_scan_equalizer_tuner.sv
// Eye-scan equalizer tuner: sweeps sampling phases, measures the vertical eye opening
// per phase, then sign-gradient searches the TX equalizer corner frequency.
module eye_scan_equalizer_tuner #(
   parameter int  NUM_PHASES        = 16,
   parameter int  SAMPLES_PER_PHASE = 64,
   parameter int  SETTLE_CYCLES     = 8,
   parameter int  MAX_ITER          = 32,
   parameter real F_INIT            = 1.0e9,
   parameter real F_STEP_INIT       = 1.0e8,
   parameter real F_STEP_MIN        = 1.0e6,
   parameter real F_MIN             = 1.0e8,
   parameter real F_MAX             = 1.0e10,
   localparam int PW                = (NUM_PHASES > 1) ? $clog2(NUM_PHASES) : 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  real           data,
   output logic [PW-1:0] phase_sel,
   output real           frequency,
   output real           opening,
   output logic [PW-1:0] best_phase,
   output logic          busy,
   output logic          done,
   output logic          converged
);
   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_SETTLE = 3'd1,
      S_ACCUM  = 3'd2,
      S_EVAL   = 3'd3,
      S_UPDATE = 3'd4,
      S_FINISH = 3'd5
   } state_e;

   state_e        state_q, state_d;
   logic [31:0]   cnt_q, cnt_d, iter_q, iter_d;
   logic [PW-1:0] phase_q, phase_d, best_ph_q, best_ph_d, bphase_q, bphase_d;
   logic          pos_seen_q, pos_seen_d, neg_seen_q, neg_seen_d;
   logic          dir_neg_q, dir_neg_d, busy_q, busy_d, done_q, done_d, conv_q, conv_d;
   real           min_pos_q, min_pos_d, max_neg_q, max_neg_d, best_open_q, best_open_d;
   real           freq_q, freq_d, open_q, open_d, step_q, step_d, prev_open_q, prev_open_d;
   real           ph_open_s, step_n_s, f_try_s;
   logic          dec_s, dir_n_s;

   // A phase with only one polarity observed has no measurable eye.
   assign ph_open_s = (pos_seen_q && neg_seen_q) ? (min_pos_q - max_neg_q) : 0.0;
   assign dec_s     = (best_open_q < prev_open_q);
   assign dir_n_s   = dec_s ? ~dir_neg_q : dir_neg_q;
   assign step_n_s  = dec_s ? (step_q * 0.5) : step_q;
   assign f_try_s   = dir_n_s ? (freq_q - step_n_s) : (freq_q + step_n_s);

   // State and datapath registers; reset restores the idle operating point.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         cnt_q       <= 32'd0;
         iter_q      <= 32'd0;
         phase_q     <= {PW{1'b0}};
         best_ph_q   <= {PW{1'b0}};
         bphase_q    <= {PW{1'b0}};
         pos_seen_q  <= 1'b0;
         neg_seen_q  <= 1'b0;
         dir_neg_q   <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         conv_q      <= 1'b0;
         min_pos_q   <= 0.0;
         max_neg_q   <= 0.0;
         best_open_q <= 0.0;
         freq_q      <= F_INIT;
         open_q      <= 0.0;
         step_q      <= F_STEP_INIT;
         prev_open_q <= -1.0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         iter_q      <= iter_d;
         phase_q     <= phase_d;
         best_ph_q   <= best_ph_d;
         bphase_q    <= bphase_d;
         pos_seen_q  <= pos_seen_d;
         neg_seen_q  <= neg_seen_d;
         dir_neg_q   <= dir_neg_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         conv_q      <= conv_d;
         min_pos_q   <= min_pos_d;
         max_neg_q   <= max_neg_d;
         best_open_q <= best_open_d;
         freq_q      <= freq_d;
         open_q      <= open_d;
         step_q      <= step_d;
         prev_open_q <= prev_open_d;
      end
   end

   // Next-state and datapath updates for the sweep / gradient-search sequence.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      iter_d      = iter_q;
      phase_d     = phase_q;
      best_ph_d   = best_ph_q;
      bphase_d    = bphase_q;
      pos_seen_d  = pos_seen_q;
      neg_seen_d  = neg_seen_q;
      dir_neg_d   = dir_neg_q;
      busy_d      = busy_q;
      done_d      = 1'b0;
      conv_d      = conv_q;
      min_pos_d   = min_pos_q;
      max_neg_d   = max_neg_q;
      best_open_d = best_open_q;
      freq_d      = freq_q;
      open_d      = open_q;
      step_d      = step_q;
      prev_open_d = prev_open_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               freq_d      = F_INIT;
               step_d      = F_STEP_INIT;
               dir_neg_d   = 1'b0;
               iter_d      = 32'd0;
               phase_d     = {PW{1'b0}};
               prev_open_d = -1.0;
               conv_d      = 1'b0;
               busy_d      = 1'b1;
               cnt_d       = 32'd0;
               state_d     = S_SETTLE;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_SETTLE: begin
            if (cnt_q == 32'(SETTLE_CYCLES - 1)) begin
               cnt_d      = 32'd0;
               pos_seen_d = 1'b0;
               neg_seen_d = 1'b0;
               min_pos_d  = 0.0;
               max_neg_d  = 0.0;
               state_d    = S_ACCUM;
            end else begin
               cnt_d = cnt_q + 32'd1;
            end
         end
         S_ACCUM: begin
            if (data > 0.0) begin
               min_pos_d  = (!pos_seen_q || (data < min_pos_q)) ? data : min_pos_q;
               pos_seen_d = 1'b1;
            end else if (data < 0.0) begin
               max_neg_d  = (!neg_seen_q || (data > max_neg_q)) ? data : max_neg_q;
               neg_seen_d = 1'b1;
            end else begin
               pos_seen_d = pos_seen_q;
            end
            if (cnt_q == 32'(SAMPLES_PER_PHASE - 1)) begin
               cnt_d   = 32'd0;
               state_d = S_EVAL;
            end else begin
               cnt_d = cnt_q + 32'd1;
            end
         end
         S_EVAL: begin
            // Strict compare keeps the lowest phase on ties.
            if ((phase_q == {PW{1'b0}}) || (ph_open_s > best_open_q)) begin
               best_open_d = ph_open_s;
               best_ph_d   = phase_q;
            end else begin
               best_open_d = best_open_q;
            end
            if (phase_q < PW'(NUM_PHASES - 1)) begin
               phase_d = phase_q + PW'(1'b1);
               state_d = S_SETTLE;
            end else begin
               state_d = S_UPDATE;
            end
         end
         S_UPDATE: begin
            open_d      = best_open_q;
            bphase_d    = best_ph_q;
            prev_open_d = best_open_q;
            step_d      = step_n_s;
            iter_d      = iter_q + 32'd1;
            phase_d     = {PW{1'b0}};
            cnt_d       = 32'd0;
            if (f_try_s > F_MAX) begin
               freq_d    = F_MAX;
               dir_neg_d = ~dir_n_s;
            end else if (f_try_s < F_MIN) begin
               freq_d    = F_MIN;
               dir_neg_d = ~dir_n_s;
            end else begin
               freq_d    = f_try_s;
               dir_neg_d = dir_n_s;
            end
            if ((step_n_s < F_STEP_MIN) || ((iter_q + 32'd1) == 32'(MAX_ITER))) begin
               busy_d  = 1'b0;
               done_d  = 1'b1;
               conv_d  = (step_n_s < F_STEP_MIN);
               state_d = S_FINISH;
            end else begin
               state_d = S_SETTLE;
            end
         end
         S_FINISH: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   assign phase_sel  = phase_q;
   assign frequency  = freq_q;
   assign opening    = open_q;
   assign best_phase = bphase_q;
   assign busy       = busy_q;
   assign done       = done_q;
   assign converged  = conv_q;

endmodule

// File: tb/tb_eye_scan_equalizer_tuner.sv
// Randomized bench for eye_scan_equalizer_tuner: a schedule-driven reference model
// computes per-phase openings and the gradient search from the drawn samples.
module tb_eye_scan_equalizer_tuner;
   localparam int  NP  = 12;
   localparam int  SPP = 6;
   localparam int  SC  = 2;
   localparam int  MI  = 16;
   localparam real FI  = 1.0e9;
   localparam real FSI = 1.0e8;
   localparam real FSM = 1.0e7;
   localparam real FMN = 1.0e8;
   localparam real FMX = 1.25e9;
   localparam real PEAK = 1.12e9;
   localparam int  PW  = $clog2(NP);

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          start = 1'b0;
   real           data = 0.0;
   logic [PW-1:0] phase_sel, best_phase;
   real           frequency, opening;
   logic          busy, done, converged;

   int  checks = 0;
   int  errors = 0;
   real m_freq, m_open, m_step, m_dir, m_prev;
   int  m_bphase, m_conv;
   real samples[SPP];

   eye_scan_equalizer_tuner #(
      .NUM_PHASES(NP), .SAMPLES_PER_PHASE(SPP), .SETTLE_CYCLES(SC), .MAX_ITER(MI),
      .F_INIT(FI), .F_STEP_INIT(FSI), .F_STEP_MIN(FSM), .F_MIN(FMN), .F_MAX(FMX)
   ) dut (
      .clk(clk), .rst(rst), .start(start), .data(data),
      .phase_sel(phase_sel), .frequency(frequency), .opening(opening),
      .best_phase(best_phase), .busy(busy), .done(done), .converged(converged)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input real got, input real exp);
      real tol;
      tol = 1.0e-9 * (((exp < 0.0) ? -exp : exp) + 1.0);
      checks++;
      if (((got - exp) > tol) || ((exp - got) > tol)) begin
         errors++;
         $display("FAIL %s got %g expected %g", tag, got, exp);
      end
   endtask

   task automatic tick(input real d, input logic st);
      data  = d;
      start = st;
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   function automatic real junk();
      return ($urandom_range(0, 1) == 1) ? 0.01 : -0.01;
   endfunction

   function automatic logic rnd_start();
      return ($urandom_range(0, 3) == 0);
   endfunction

   function automatic real gen(input int mode, input int ph, input int k, input real f);
      real amp, d;
      amp = 0.0;
      case (mode)
         0: return 0.5;
         1: return ((k % 2) == 0) ? 1.0 : -1.0;
         2: amp = (ph == 11) ? 0.8 : 0.3;
         3: amp = 0.9 - ((f > PEAK) ? (f - PEAK) : (PEAK - f)) / 1.0e10;
         default: return (real'($urandom_range(0, 20)) - 10.0) / 8.0;
      endcase
      if (k == 0) return amp;
      if (k == 1) return -amp;
      d = amp + real'($urandom_range(0, 50)) / 100.0;
      return ($urandom_range(0, 1) == 1) ? d : -d;
   endfunction

   task automatic apply_reset();
      #2;
      rst = 1'b1;
      #1;
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_conv", converged, 0);
      check("rst_phase_sel", phase_sel, 0);
      check("rst_best_phase", best_phase, 0);
      check("rst_frequency", frequency, FI);
      check("rst_opening", opening, 0.0);
      m_open = 0.0; m_bphase = 0; m_conv = 0;
      @(posedge clk);
      #1;
      check("rst_no_done", done, 0);
      rst = 1'b0;
      tick(0.0, 1'b0);
      check("rst_idle", busy, 0);
   endtask

   task automatic run(input int mode, input int abort_iter);
      int  it;
      bit  fin;
      real best, po, mn, mx, f;
      int  bp;
      bit  hp, hn;
      m_freq = FI; m_step = FSI; m_dir = 1.0; m_prev = -1.0; m_conv = 0;
      tick(junk(), 1'b1);
      check("busy_after_start", busy, 1);
      check("conv_cleared", converged, 0);
      fin = 1'b0;
      it  = 0;
      while (!fin && (it < MI)) begin
         best = -1.0;
         bp   = 0;
         for (int p = 0; p < NP; p++) begin
            for (int s = 0; s < SC; s++) begin
               tick(junk(), rnd_start());
               if (s == 0) check("phase_sel", phase_sel, p);
            end
            hp = 1'b0; hn = 1'b0; mn = 0.0; mx = 0.0;
            for (int k = 0; k < SPP; k++) begin
               if ((it == abort_iter) && (p == 1) && (k == 2)) begin
                  check("busy_before_abort", busy, 1);
                  apply_reset();
                  return;
               end
               samples[k] = gen(mode, p, k, m_freq);
               tick(samples[k], rnd_start());
            end
            foreach (samples[k]) begin
               if (samples[k] > 0.0 && (!hp || samples[k] < mn)) begin mn = samples[k]; hp = 1'b1; end
               if (samples[k] < 0.0 && (!hn || samples[k] > mx)) begin mx = samples[k]; hn = 1'b1; end
            end
            po = (hp && hn) ? (mn - mx) : 0.0;
            if (po > best) begin best = po; bp = p; end
            tick(junk(), rnd_start());
         end
         check("opening_hold", opening, m_open);
         tick(junk(), rnd_start());
         m_open = best;
         m_bphase = bp;
         if (best < m_prev) begin m_dir = -m_dir; m_step = m_step / 2.0; end
         f = m_freq + m_dir * m_step;
         if (f > FMX) begin f = FMX; m_dir = -m_dir; end
         else if (f < FMN) begin f = FMN; m_dir = -m_dir; end
         m_freq = f;
         m_prev = best;
         it++;
         fin = (m_step < FSM) || (it == MI);
         check("opening", opening, m_open);
         check("best_phase", best_phase, m_bphase);
         check("frequency", frequency, m_freq);
         check("done", done, fin);
         check("busy", busy, !fin);
      end
      m_conv = (m_step < FSM) ? 1 : 0;
      check("converged", converged, m_conv);
      tick(junk(), 1'b1);
      check("done_pulse_end", done, 0);
      check("conv_hold", converged, m_conv);
      check("freq_hold", frequency, m_freq);
      tick(junk(), 1'b0);
      check("start_in_finish_ignored", busy, 0);
   endtask

   initial begin
      real diff;
      apply_reset();
      run(0, -1);
      check("const_not_converged", converged, 0);
      run(1, -1);
      check("alt_opening", opening, 2.0);
      check("alt_best_phase", best_phase, 0);
      run(2, -1);
      check("ph11_opening", opening, 1.6);
      check("ph11_best_phase", best_phase, 11);
      run(3, -1);
      check("peak_converged", converged, 1);
      diff = frequency - PEAK;
      check("peak_near", ((diff < FSM) && (diff > -FSM)) ? 1 : 0, 1);
      run(4, -1);
      run(4, -1);
      run(3, 3);
      run(1, -1);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
